// File: rtl/nexus_pkg.sv
// Shared constants and helpers for the nexus pipelined priority encoder.
package nexus_pkg;

  // Run-time search modes; the encoding 2'd3 is reserved and behaves as MODE_LOW.
  localparam logic [1:0] MODE_LOW  = 2'd0;
  localparam logic [1:0] MODE_HIGH = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;

  // Index width for a vector of n bits (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nexus_grp_enc.sv
// Combinational GROUP-bit encoder: reports whether any bit is set and the
// offsets of the lowest and highest set bits (both 0 when nothing is set).
module nexus_grp_enc
  import nexus_pkg::*;
#(
  parameter int GROUP = 16,
  parameter int LO_W  = idx_width(GROUP)
) (
  input  logic [GROUP-1:0] data_i,
  output logic             any_o,
  output logic [LO_W-1:0]  lo_o,
  output logic [LO_W-1:0]  hi_o
);

  // Downward scan leaves the lowest set bit in lo_o; upward scan leaves the highest in hi_o.
  always_comb begin
    any_o = |data_i;
    lo_o  = '0;
    hi_o  = '0;
    for (int i = GROUP - 1; i >= 0; i--) begin
      if (data_i[i]) lo_o = LO_W'(i);
    end
    for (int i = 0; i < GROUP; i++) begin
      if (data_i[i]) hi_o = LO_W'(i);
    end
  end

endmodule

// File: rtl/nexus_pri_enc_pipe.sv
// Two-stage pipelined priority encoder for wide PIFO occupancy vectors.
// Stage 1 reduces each GROUP-bit slice to any/lo/hi; stage 2 picks the
// winning group according to the mode and loads the output register.
//
// Handshake: a request moves in on the edge where i_valid && o_ready, a result
// moves out on the edge where o_valid && i_ready. o_valid/o_index/o_found hold
// steady while o_valid && !i_ready, and every accepted request yields exactly
// one result, in order.
module nexus_pri_enc_pipe
  import nexus_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUP = 16,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_index,
  output logic             o_found,
  output logic [IDX_W-1:0] o_rr_ptr
);

  localparam int NG   = WIDTH / GROUP;
  localparam int LO_W = idx_width(GROUP);

  // ---------------- stage 1: per-group reduction ----------------
  logic [NG-1:0]   g_any;
  logic [LO_W-1:0] g_lo [NG];
  logic [LO_W-1:0] g_hi [NG];

  for (genvar g = 0; g < NG; g++) begin : g_s1_enc
    nexus_grp_enc #(.GROUP(GROUP)) u_enc (
      .data_i (i_data[g*GROUP +: GROUP]),
      .any_o  (g_any[g]),
      .lo_o   (g_lo[g]),
      .hi_o   (g_hi[g])
    );
  end

  logic             s1_valid_q;
  logic [NG-1:0]    s1_any_q;
  logic [LO_W-1:0]  s1_lo_q [NG];
  logic [LO_W-1:0]  s1_hi_q [NG];
  logic [WIDTH-1:0] s1_data_q;
  logic [1:0]       s1_mode_q;

  logic             o_valid_q;
  logic             o_found_q;
  logic [IDX_W-1:0] o_index_q;
  logic [IDX_W-1:0] rr_ptr_q;

  // s2 may take new content when empty or when its current result leaves this edge.
  logic s2_can_load;
  assign s2_can_load = !o_valid_q || i_ready;
  assign o_ready     = !s1_valid_q || s2_can_load;

  // Stage 1 register: captures the group summaries, raw data and mode on input transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
    end else if (o_ready) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_any_q  <= g_any;
        s1_lo_q   <= g_lo;
        s1_hi_q   <= g_hi;
        s1_data_q <= i_data;
        s1_mode_q <= i_mode;
      end
    end
  end

  // ---------------- stage 2: round-robin pointer group ----------------
  // The group holding rr_ptr needs a bit-exact search above the pointer
  // offset, so it is re-encoded from raw data with lower offsets masked off.
  logic [IDX_W-1:0] ptr_grp;
  logic [IDX_W-1:0] ptr_base;
  logic [LO_W-1:0]  ptr_off;
  logic [GROUP-1:0] above_mask;
  logic [GROUP-1:0] m_data;
  logic             m_any;
  logic [LO_W-1:0]  m_lo;
  logic [LO_W-1:0]  unused_m_hi;

  assign ptr_grp    = rr_ptr_q >> LO_W;
  assign ptr_base   = ptr_grp << LO_W;
  assign ptr_off    = rr_ptr_q[LO_W-1:0];
  assign above_mask = ({GROUP{1'b1}} << ptr_off) << 1;

  // Select the pointer's group out of the raw stage-1 data and keep only bits above the pointer.
  always_comb begin
    m_data = '0;
    for (int g = 0; g < NG; g++) begin
      if (ptr_grp == IDX_W'(g)) m_data = s1_data_q[g*GROUP +: GROUP];
    end
    m_data = m_data & above_mask;
  end

  nexus_grp_enc #(.GROUP(GROUP)) u_enc_ptr (
    .data_i (m_data),
    .any_o  (m_any),
    .lo_o   (m_lo),
    .hi_o   (unused_m_hi)
  );

  // ---------------- stage 2: result selection ----------------
  logic             low_found, high_found, up_found, found_d;
  logic [IDX_W-1:0] low_idx, high_idx, up_idx, idx_d;

  // Combine group summaries per mode; every index is 0 when nothing qualifies.
  always_comb begin
    low_found  = 1'b0;
    low_idx    = '0;
    high_found = 1'b0;
    high_idx   = '0;
    up_found   = 1'b0;
    up_idx     = '0;
    found_d    = 1'b0;
    idx_d      = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_any_q[g]) begin
        low_found = 1'b1;
        low_idx   = IDX_W'(g * GROUP) + IDX_W'(s1_lo_q[g]);
      end
      // Nearest non-empty group strictly above the pointer's group.
      if (s1_any_q[g] && (IDX_W'(g) > ptr_grp)) begin
        up_found = 1'b1;
        up_idx   = IDX_W'(g * GROUP) + IDX_W'(s1_lo_q[g]);
      end
    end
    for (int g = 0; g < NG; g++) begin
      if (s1_any_q[g]) begin
        high_found = 1'b1;
        high_idx   = IDX_W'(g * GROUP) + IDX_W'(s1_hi_q[g]);
      end
    end
    case (s1_mode_q)
      MODE_HIGH: begin
        found_d = high_found;
        idx_d   = high_idx;
      end
      MODE_RR: begin
        // Above the pointer first; otherwise wrap to the overall lowest set bit,
        // which re-grants the pointer itself when it is the only set bit.
        if (m_any) begin
          found_d = 1'b1;
          idx_d   = ptr_base + IDX_W'(m_lo);
        end else if (up_found) begin
          found_d = 1'b1;
          idx_d   = up_idx;
        end else begin
          found_d = low_found;
          idx_d   = low_idx;
        end
      end
      default: begin
        found_d = low_found;
        idx_d   = low_idx;
      end
    endcase
  end

  // Output register and round-robin pointer; both frozen while the output is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_found_q <= 1'b0;
      o_index_q <= '0;
      rr_ptr_q  <= IDX_W'(WIDTH - 1);
    end else if (s2_can_load) begin
      o_valid_q <= s1_valid_q;
      o_found_q <= s1_valid_q && found_d;
      o_index_q <= s1_valid_q ? idx_d : '0;
      if (s1_valid_q && found_d && (s1_mode_q == MODE_RR)) begin
        rr_ptr_q <= idx_d;
      end
    end
  end

  assign o_valid  = o_valid_q;
  assign o_found  = o_found_q;
  assign o_index  = o_index_q;
  assign o_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_nexus_pri_enc_pipe.sv
// Bench for nexus_pri_enc_pipe: directed table, hand-written multi-cycle
// sequences, randomized traffic against a reference model, and a small
// 24-bit build for the explicit index wrap.
module tb_nexus_pri_enc_pipe;

  localparam int WIDTH = 64;
  localparam int IDX_W = 6;
  localparam int EW    = 1 + 2 * IDX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst;
  logic             i_valid, o_ready, o_valid, i_ready, o_found;
  logic [WIDTH-1:0] i_data;
  logic [1:0]       i_mode;
  logic [IDX_W-1:0] o_index, o_rr_ptr;

  logic        v24, ordy24, ov24, rdy24, found24;
  logic [23:0] d24;
  logic [1:0]  m24;
  logic [4:0]  idx24, ptr24;

  nexus_pri_enc_pipe #(.WIDTH(64), .GROUP(16)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_index(o_index), .o_found(o_found), .o_rr_ptr(o_rr_ptr)
  );

  nexus_pri_enc_pipe #(.WIDTH(24), .GROUP(8)) u_dut24 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(v24), .o_ready(ordy24),
    .i_data(d24), .i_mode(m24), .o_valid(ov24), .i_ready(rdy24),
    .o_index(idx24), .o_found(found24), .o_rr_ptr(ptr24)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int model_ptr = WIDTH - 1;
  logic stall_seen = 1'b0;
  logic [IDX_W-1:0] held_idx;
  logic held_found;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain scans over the bit vector; RR walks ptr+1, ptr+2, ... modulo WIDTH.
  function automatic logic [EW-1:0] model_pick(input logic [WIDTH-1:0] d, input logic [1:0] m);
    int sel = -1;
    if (m == 2'd1) begin
      for (int i = 0; i < WIDTH; i++) if (d[i]) sel = i;
    end else if (m == 2'd2) begin
      for (int j = WIDTH; j >= 1; j--) if (d[(model_ptr + j) % WIDTH]) sel = (model_ptr + j) % WIDTH;
      if (sel >= 0) model_ptr = sel;
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) sel = i;
    end
    if (sel < 0) return {1'b0, 6'd0, 6'(model_ptr)};
    return {1'b1, 6'(sel), 6'(model_ptr)};
  endfunction

  // Monitor: stall stability, in-order result checking, request capture.
  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      model_ptr  = WIDTH - 1;
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", o_valid, 1);
        check("stall_idx", o_index, held_idx);
        check("stall_found", o_found, held_found);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("sb_found", o_found, e[12]);
          check("sb_idx", o_index, e[11:6]);
          check("sb_rr_ptr", o_rr_ptr, e[5:0]);
        end
      end
      stall_seen = o_valid && !i_ready;
      held_idx   = o_index;
      held_found = o_found;
      if (i_valid && o_ready) exp_q.push_back(model_pick(i_data, i_mode));
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic drive(input logic [WIDTH-1:0] d, input logic [1:0] m);
    int n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) check("drive_timeout_o_ready", o_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic get_result(output logic [IDX_W-1:0] idx, output logic found,
                            output logic [IDX_W-1:0] ptr, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 50);
    if (!o_valid) check("result_timeout_o_valid", o_valid, 1);
    idx   = o_index;
    found = o_found;
    ptr   = o_rr_ptr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    logic [WIDTH-1:0] d = '0;
    case ($urandom_range(0, 3))
      0: d = '0;
      1: d[$urandom_range(0, WIDTH - 1)] = 1'b1;
      2: repeat (3) d[$urandom_range(0, WIDTH - 1)] = 1'b1;
      default: d = {$urandom, $urandom};
    endcase
    return d;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
    logic [IDX_W-1:0] idx;
    logic             found;
  } vec_t;

  vec_t tbl[9];
  int rr_exp[4] = '{3, 17, 63, 3};
  logic [4:0] exp24[2] = '{5'd2, 5'd23};
  logic [IDX_W-1:0] r_idx, r_ptr;
  logic r_found;
  int r_lat;
  logic saw_block;
  logic done_flag;
  int n;

  initial begin
    tbl[0] = '{64'h0000_0100_0000_0020, 2'd0, 6'd5,  1'b1};  // bits 5,40 low
    tbl[1] = '{64'h0000_0100_0000_0020, 2'd1, 6'd40, 1'b1};  // bits 5,40 high
    tbl[2] = '{64'h0000_0000_0000_0180, 2'd3, 6'd7,  1'b1};  // mode 3 as low
    tbl[3] = '{64'h0000_0000_0000_0000, 2'd0, 6'd0,  1'b0};
    tbl[4] = '{64'h0000_0000_0000_0000, 2'd1, 6'd0,  1'b0};
    tbl[5] = '{64'h8000_0000_0000_0000, 2'd0, 6'd63, 1'b1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 6'd63, 1'b1};
    tbl[7] = '{64'h0000_8000_0001_0000, 2'd0, 6'd16, 1'b1};  // group edges
    tbl[8] = '{64'h0000_8000_0001_0000, 2'd1, 6'd47, 1'b1};

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_mode = 2'd0; i_ready = 1'b1;
    v24 = 1'b0; d24 = '0; m24 = 2'd0; rdy24 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;

    check("rst_o_valid", o_valid, 0);
    check("rst_o_found", o_found, 0);
    check("rst_o_index", o_index, 0);
    check("rst_rr_ptr", o_rr_ptr, 63);
    check("rst_o_ready", o_ready, 1);
    check("rst_rr_ptr24", ptr24, 23);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].data, tbl[i].mode);
      get_result(r_idx, r_found, r_ptr, r_lat);
      check("tbl_idx", r_idx, tbl[i].idx);
      check("tbl_found", r_found, tbl[i].found);
      check("tbl_rr_ptr_unchanged", r_ptr, 63);
      if (i == 0) check("latency_2", r_lat, 2);
    end

    // Round-robin rotation, back-to-back.
    fork
      begin
        for (int k = 0; k < 4; k++) drive(64'h8000_0000_0002_0008, 2'd2);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          get_result(r_idx, r_found, r_ptr, r_lat);
          check("rr_idx", r_idx, rr_exp[k]);
          check("rr_ptr", r_ptr, rr_exp[k]);
          if (k > 0) check("rr_b2b_lat", r_lat, 1);
        end
      end
    join

    // Move pointer to 9, re-grant 9, then all-zero leaves pointer alone.
    drive(64'h200, 2'd2);
    get_result(r_idx, r_found, r_ptr, r_lat);
    check("rr_to9_idx", r_idx, 9);
    drive(64'h200, 2'd2);
    get_result(r_idx, r_found, r_ptr, r_lat);
    check("rr_regrant_idx", r_idx, 9);
    check("rr_regrant_ptr", r_ptr, 9);
    drive(64'h0, 2'd2);
    get_result(r_idx, r_found, r_ptr, r_lat);
    check("rr_zero_found", r_found, 0);
    check("rr_zero_idx", r_idx, 0);
    check("rr_zero_ptr", r_ptr, 9);

    // Backpressure: downstream stalled for six cycles.
    i_ready = 1'b0;
    saw_block = 1'b0;
    fork
      begin
        drive(64'h2, 2'd0); drive(64'h4, 2'd0); drive(64'h8, 2'd0); drive(64'h10, 2'd0);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (!o_ready) saw_block = 1'b1;
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          get_result(r_idx, r_found, r_ptr, r_lat);
          check("bp_order_idx", r_idx, k + 1);
        end
      end
    join
    check("bp_o_ready_dropped", saw_block, 1);
    @(negedge clk);
    check("bp_no_extra_output", o_valid, 0);
    @(posedge clk);
    #1;

    // Reset with both stages occupied.
    i_ready = 1'b0;
    drive(64'h20, 2'd0);
    drive(64'h20, 2'd0);
    @(negedge clk);
    check("midrst_pre_full_ready", o_ready, 0);
    check("midrst_pre_valid", o_valid, 1);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_rr_ptr", o_rr_ptr, 63);
    check("midrst_o_ready", o_ready, 1);
    i_ready = 1'b1;
    drive(64'h8000_0000_0000_0001, 2'd2);
    get_result(r_idx, r_found, r_ptr, r_lat);
    check("midrst_rr_idx", r_idx, 0);
    check("midrst_rr_ptr_after", r_ptr, 0);

    // 24-bit build: wrap from pointer 23 back to bit 2, then on to 23.
    for (int k = 0; k < 2; k++) begin
      check("w24_ready", ordy24, 1);
      v24 = 1'b1; d24 = 24'h80_0004; m24 = 2'd2;
      @(posedge clk);
      #1;
      v24 = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ov24 && n < 10);
      check("w24_valid", ov24, 1);
      check("w24_idx", idx24, exp24[k]);
      check("w24_found", found24, 1);
      check("w24_ptr", ptr24, exp24[k]);
      @(posedge clk);
      #1;
    end

    // Randomized traffic with random backpressure; scoreboard checks every result.
    done_flag = 1'b0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          drive(rand_data(), 2'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
        end
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
